// File: rtl/accumulator_core.sv
// accumulator_core: registered running sum of an unsigned input sample.
// A sample is consumed on every clock edge. The total either wraps modulo
// 2^SUM_W or clamps at all-ones, depending on SATURATE. A saturating sample
// counter and a sticky overflow flag report status alongside the total.
module accumulator_core #(
  parameter int IN_W     = 16,
  parameter int SUM_W    = 24,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  output logic [SUM_W-1:0] sum,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic [SUM_W:0]   w_nextFull;
  logic             w_carry;
  logic [SUM_W-1:0] w_nextSum;
  logic [CNT_W-1:0] w_nextCount;

  // The add is one bit wider than the total, so the top bit is the carry-out
  // that marks an overflowing add.
  always_comb begin
    w_nextFull = {1'b0, r_sum} + {{(SUM_W + 1 - IN_W){1'b0}}, in};
    w_carry    = w_nextFull[SUM_W];
  end

  // Choose between wrap-around and clamping when the add overflows.
  always_comb begin
    w_nextSum = w_nextFull[SUM_W-1:0];
    if (w_carry && SATURATE) begin
      w_nextSum = '1;
    end
  end

  // The sample counter stops at all-ones instead of rolling over to zero.
  always_comb begin
    w_nextCount = r_count;
    if (r_count != '1) begin
      w_nextCount = r_count + 1'b1;
    end
  end

  // State update. Reset wins over accumulation and discards the sample
  // present at that edge. The overflow flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sum   <= w_nextSum;
      r_count <= w_nextCount;
      if (w_carry) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign sum      = r_sum;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_accumulator_core.sv
// tb_accumulator_core: drives three accumulator_core instances with the same
// input stream: a wrapping one, a saturating one, and a wrapping one with a
// 4-bit counter, so that counter saturation is reachable in a short run.
module tb_accumulator_core;

  localparam int  IN_W    = 16;
  localparam int  SUM_W   = 24;
  localparam int  CNT_W   = 16;
  localparam longint SUM_MOD   = 64'd1 << SUM_W;
  localparam longint SUM_MAX   = SUM_MOD - 1;
  localparam int  CNT_MAX      = (1 << CNT_W) - 1;
  localparam int  CNT_MAX_SMALL = 15;

  logic             clk;
  logic             rst;
  logic [IN_W-1:0]  in;

  logic [SUM_W-1:0] sumWrap, sumSat, sumSmall;
  logic [CNT_W-1:0] countWrap, countSat;
  logic [3:0]       countSmall;
  logic             ovfWrap, ovfSat, ovfSmall;

  int checks   = 0;
  int failures = 0;

  // Behavioural reference state, updated from the arithmetic rules alone.
  longint refWrap, refSat;
  int     refCnt, refCntSmall;
  bit     refOvfWrap, refOvfSat;

  typedef struct {
    bit               rst;
    logic [IN_W-1:0]  in;
    logic [SUM_W-1:0] expSum;
    logic [CNT_W-1:0] expCount;
    bit               expOvf;
  } vec_t;

  vec_t vecs[$];

  accumulator_core #(.IN_W(IN_W), .SUM_W(SUM_W), .SATURATE(1'b0), .CNT_W(CNT_W)) dutWrap (
    .clk(clk), .rst(rst), .in(in), .sum(sumWrap), .count(countWrap), .overflow(ovfWrap)
  );

  accumulator_core #(.IN_W(IN_W), .SUM_W(SUM_W), .SATURATE(1'b1), .CNT_W(CNT_W)) dutSat (
    .clk(clk), .rst(rst), .in(in), .sum(sumSat), .count(countSat), .overflow(ovfSat)
  );

  accumulator_core #(.IN_W(IN_W), .SUM_W(SUM_W), .SATURATE(1'b0), .CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .in(in), .sum(sumSmall), .count(countSmall), .overflow(ovfSmall)
  );

  // 10 ns clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison: counts it and reports a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one sample, let one rising edge consume it, advance the reference
  // model, and return 1 ns after the edge so outputs are sampled off-edge.
  task automatic applyStimulus(input bit r, input logic [IN_W-1:0] v);
    longint full;
    rst = r;
    in  = v;
    @(posedge clk);
    #1;
    if (r) begin
      refWrap = 0; refSat = 0; refCnt = 0; refCntSmall = 0;
      refOvfWrap = 0; refOvfSat = 0;
    end else begin
      full = refWrap + longint'(v);
      if (full > SUM_MAX) refOvfWrap = 1;
      refWrap = full % SUM_MOD;
      full = refSat + longint'(v);
      if (full > SUM_MAX) begin
        refOvfSat = 1;
        refSat = SUM_MAX;
      end else begin
        refSat = full;
      end
      if (refCnt < CNT_MAX) refCnt++;
      if (refCntSmall < CNT_MAX_SMALL) refCntSmall++;
    end
  endtask

  // Compare every instance against the reference model.
  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, " wrap sum"},    32'(sumWrap),    32'(refWrap));
    checkOutput({tag, " wrap count"},  32'(countWrap),  32'(refCnt));
    checkOutput({tag, " wrap ovf"},    32'(ovfWrap),    32'(refOvfWrap));
    checkOutput({tag, " sat sum"},     32'(sumSat),     32'(refSat));
    checkOutput({tag, " sat ovf"},     32'(ovfSat),     32'(refOvfSat));
    checkOutput({tag, " small count"}, 32'(countSmall), 32'(refCntSmall));
    checkOutput({tag, " small sum"},   32'(sumSmall),   32'(refWrap));
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    in  = '0;

    // Reset with a non-zero sample, basic accumulation, mid-run reset.
    vecs.push_back('{1'b1, 16'h1234, 24'd0,   16'd0, 1'b0});
    vecs.push_back('{1'b1, 16'h1234, 24'd0,   16'd0, 1'b0});
    vecs.push_back('{1'b0, 16'd1,    24'd1,   16'd1, 1'b0});
    vecs.push_back('{1'b0, 16'd2,    24'd3,   16'd2, 1'b0});
    vecs.push_back('{1'b0, 16'd3,    24'd6,   16'd3, 1'b0});
    vecs.push_back('{1'b0, 16'd4,    24'd10,  16'd4, 1'b0});
    vecs.push_back('{1'b0, 16'd0,    24'd10,  16'd5, 1'b0});
    vecs.push_back('{1'b0, 16'd90,   24'd100, 16'd6, 1'b0});
    vecs.push_back('{1'b1, 16'd7,    24'd0,   16'd0, 1'b0});
    vecs.push_back('{1'b0, 16'd7,    24'd7,   16'd1, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.rst, v.in);
      checkOutput($sformatf("vec%0d wrap sum", i),   32'(sumWrap),   32'(v.expSum));
      checkOutput($sformatf("vec%0d wrap count", i), 32'(countWrap), 32'(v.expCount));
      checkOutput($sformatf("vec%0d wrap ovf", i),   32'(ovfWrap),   32'(v.expOvf));
      checkOutput($sformatf("vec%0d sat sum", i),    32'(sumSat),    32'(v.expSum));
      checkOutput($sformatf("vec%0d sat ovf", i),    32'(ovfSat),    32'(v.expOvf));
    end

    // Maximum input: 256 x 0xFFFF reaches 0xFFFF00 without overflow.
    applyStimulus(1'b1, 16'h0);
    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 16'hFFFF);
    checkOutput("max wrap sum",   32'(sumWrap),    32'hFF_FF00);
    checkOutput("max wrap ovf",   32'(ovfWrap),    32'd0);
    checkOutput("max sat sum",    32'(sumSat),     32'hFF_FF00);
    checkOutput("max sat ovf",    32'(ovfSat),     32'd0);
    checkOutput("max count",      32'(countWrap),  32'd256);
    checkOutput("max small cnt",  32'(countSmall), 32'd15);

    // One more 0x0100 crosses the top: wrap to zero vs clamp at all-ones.
    applyStimulus(1'b0, 16'h0100);
    checkOutput("cross wrap sum", 32'(sumWrap), 32'h00_0000);
    checkOutput("cross wrap ovf", 32'(ovfWrap), 32'd1);
    checkOutput("cross sat sum",  32'(sumSat),  32'hFF_FFFF);
    checkOutput("cross sat ovf",  32'(ovfSat),  32'd1);

    // Further small sample: wrap resumes from zero, clamp holds, flags stick.
    applyStimulus(1'b0, 16'd5);
    checkOutput("after wrap sum", 32'(sumWrap),   32'd5);
    checkOutput("after wrap ovf", 32'(ovfWrap),   32'd1);
    checkOutput("after sat sum",  32'(sumSat),    32'hFF_FFFF);
    checkOutput("after sat ovf",  32'(ovfSat),    32'd1);
    checkOutput("after count",    32'(countWrap), 32'd258);

    // Zero samples keep the flags and sums, count still moves.
    applyStimulus(1'b0, 16'd0);
    checkOutput("zero wrap sum",  32'(sumWrap),   32'd5);
    checkOutput("zero count",     32'(countWrap), 32'd259);
    checkOutput("zero wrap ovf",  32'(ovfWrap),   32'd1);

    // Randomized run against the reference model, with occasional resets.
    applyStimulus(1'b1, 16'h0);
    checkAgainstModel("rstrand");
    for (int i = 0; i < 1000; i++) begin
      logic [IN_W-1:0] s;
      bit r;
      r = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0:       s = 16'(($urandom_range(0, 15)));
        1:       s = 16'hFFFF;
        default: s = 16'($urandom);
      endcase
      applyStimulus(r, s);
      checkAgainstModel($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accumulator_core.md
# accumulator_core

Running-sum block for the `ac_if` accumulator environment. On every clock it adds the unsigned input sample to an internal registered total and drives that total on `sum`. Optional status outputs report how many samples have been accumulated and whether the total has ever overflowed. The test program drives `in` through the interface and checks `sum` against a reference model.

## Interface
Parameters:
- `IN_W`, default 16: width of the input sample.
- `SUM_W`, default 24: width of the accumulated total. `SUM_W` must be ≥ `IN_W`.
- `SATURATE`, default 0: selects overflow handling. 0 = modulo-2^SUM_W wrap-around; 1 = clamp at all-ones.
- `CNT_W`, default 16: width of the sample counter.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `in`  input  `IN_W`: unsigned sample, added every cycle.
- `sum`  output  `SUM_W`: registered running total.
- `count`  output  `CNT_W`: number of samples accumulated since reset.
- `overflow`  output  1: sticky flag, set when any addition exceeded 2^SUM_W−1.

The environment connects only `clk`, `rst`, `in` and `sum`. The other outputs may be left unconnected.

## Operation
- All arithmetic is unsigned. `in` is zero-extended to `SUM_W+1` bits before the add.
- Each rising edge with `rst`=0:
  - next_full = `sum` + zext(`in`), computed at `SUM_W+1` bits.
  - If next_full[SUM_W] = 0: `sum` ← next_full[SUM_W-1:0].
  - If next_full[SUM_W] = 1 and `SATURATE`=0: `sum` ← next_full[SUM_W-1:0] (wrap-around). `overflow` ← 1.
  - If next_full[SUM_W] = 1 and `SATURATE`=1: `sum` ← all-ones. `overflow` ← 1.
  - Saturated `sum` stays at all-ones while further inputs arrive. Each add that would exceed the maximum keeps `overflow` at 1.
  - `count` ← `count`+1. It saturates at all-ones and never wraps.
- `in`=0 is a legal sample: `sum` holds its value, and `count` still increments.
- No enable input exists. A sample is consumed every cycle.
- `overflow` is cleared only by reset.

## Timing
- `rst` is sampled on the rising edge of `clk`. Reset has priority over accumulation.
  - Edge with `rst`=1: `sum`=0, `count`=0, `overflow`=0. The `in` value at that edge is discarded.
  - Asserting `rst` mid-accumulation clears all state at the next edge, with no partial add.
- Outputs are registered with no combinational path from `in`. Latency is one cycle: the value of `in` sampled at edge k is reflected in `sum` after edge k.
- The first edge with `rst`=0 accumulates the `in` present at that edge.
- Before the first reset edge, output values are undefined. The environment holds `rst` high for the first two edges (20 ns at a 10 ns period).

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in`=0x1234 → `sum`=0, `count`=0, `overflow`=0; after reset release `sum` starts from 0, not 0x1234.
- Basic accumulation: after reset drive `in`=1,2,3,4 on consecutive edges → `sum`=1,3,6,10 one cycle after each, `count`=1..4.
- Maximum input (`IN_W`=16, `SUM_W`=24): drive `in`=0xFFFF for 256 cycles → `sum`=0xFFFF00, no overflow; a further 0x0100 → `sum`=0x000000 (wrap), `overflow`=1 and it stays 1 afterwards.
- Saturation (`SATURATE`=1): same sequence → `sum` clamps at 0xFFFFFF, `overflow`=1; additional `in`=5 keeps `sum`=0xFFFFFF.
- Mid-run reset: accumulate to `sum`=100, assert `rst` for 1 cycle with `in`=7 → `sum`=0 and `count`=0 next cycle; with `in`=7 on the next edge after release → `sum`=7.
- Randomized: 1000 random `in` values checked against a modulo-2^24 reference sum every cycle, with zero mismatches.
